// File: rtl/axi_lite_regif_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_pkg
//  Purpose  : Shared response codes and FSM state encodings for the AXI4-Lite
//             register-interface slave.
//  Contents : RESP_OKAY / RESP_SLVERR, write FSM states, read FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_regif_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_regif_slave_if
//  Purpose  : AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//  Modports : master - drives addresses/data/ready-for-response
//             slave  - drives channel readies and responses
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_regif_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RVALID
    );

endinterface
`default_nettype wire

// File: rtl/axi_lite_regif_slave_rd_path.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_rd_path
//  Purpose  : AXI4-Lite read channel engine. Accepts one AR, decodes the
//             register index, issues a one-cycle backend read request and
//             waits (bounded by RD_TIMEOUT) for the backend completion.
//  Ports    : clk/rst            - clock, synchronous active-high reset
//             i_araddr/i_arvalid/o_arready - AR channel
//             o_rdata/o_rresp/o_rvalid/i_rready - R channel
//             o_rd_en/o_rd_idx   - backend read request
//             i_rd_data/i_rd_valid/i_rd_err - backend completion
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_rd_path
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int RD_TIMEOUT = 16,
    localparam int STRB_W    = DATA_W / 8,
    localparam int IDX_W     = $clog2(NUM_REGS),
    localparam int LSB       = $clog2(STRB_W),
    localparam int CNT_W     = $clog2(RD_TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic              o_rd_en,
    output logic [IDX_W-1:0]  o_rd_idx,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_valid,
    input  logic              i_rd_err
);
    localparam int FULL_W = ADDR_W - LSB;

    r_state_t          r_state;
    r_state_t          w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_arready;
    logic              w_ar_hs;
    logic              w_ar_ok;
    logic              w_cnt_last;
    logic [FULL_W-1:0] w_ar_full;

    assign w_arready  = (r_state == R_IDLE);
    assign w_ar_hs    = i_arvalid && w_arready;
    assign w_ar_full  = i_araddr[ADDR_W-1:LSB];
    assign w_ar_ok    = (32'(w_ar_full) < 32'(NUM_REGS));
    assign w_cnt_last = (r_cnt == CNT_W'(RD_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // rd_en is the first R_WAIT cycle (counter still 0); rd_valid in the
    // final count cycle completes normally rather than timing out.
    always_comb begin
        w_next   = r_state;
        o_rd_en  = 1'b0;
        o_rvalid = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_next = w_ar_ok ? R_WAIT : R_RESP;
                end
            end
            R_WAIT: begin
                o_rd_en = (r_cnt == '0);
                if (i_rd_valid || w_cnt_last) begin
                    w_next = R_RESP;
                end
            end
            R_RESP: begin
                o_rvalid = 1'b1;
                if (i_rready) begin
                    w_next = R_IDLE;
                end
            end
            default: w_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_cnt <= '0;
                r_idx <= i_araddr[LSB +: IDX_W];
                if (!w_ar_ok) begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end
            end else if (r_state == R_WAIT) begin
                if (i_rd_valid) begin
                    r_rdata <= i_rd_data;
                    r_rresp <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
                end else if (w_cnt_last) begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_arready = w_arready;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign o_rd_idx  = r_idx;

endmodule
`default_nettype wire

// File: rtl/axi_lite_regif_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_regif_slave
//  Purpose  : Parametrised AXI4-Lite slave front end for the SPI bridge
//             register bank. Translates AXI writes/reads into single-cycle
//             backend strobes; holds no register storage itself.
//  Ports    : ACLK/ARESET - clock, synchronous active-high reset
//             s_axi       - AXI4-Lite slave modport (AW/W/B/AR/R)
//             wr_en/wr_idx/wr_data/wr_strb/wr_err - backend write port
//             rd_en/rd_idx/rd_data/rd_valid/rd_err - backend read port
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regif_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int RD_TIMEOUT = 16,
    localparam int STRB_W    = DATA_W / 8,
    localparam int IDX_W     = $clog2(NUM_REGS),
    localparam int LSB       = $clog2(STRB_W)
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    axi_lite_regif_slave_if.slave  s_axi,
    output logic                   wr_en,
    output logic [IDX_W-1:0]       wr_idx,
    output logic [DATA_W-1:0]      wr_data,
    output logic [STRB_W-1:0]      wr_strb,
    input  logic                   wr_err,
    output logic                   rd_en,
    output logic [IDX_W-1:0]       rd_idx,
    input  logic [DATA_W-1:0]      rd_data,
    input  logic                   rd_valid,
    input  logic                   rd_err
);
    localparam int FULL_W = ADDR_W - LSB;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t          r_wstate;
    w_state_t          w_wnext;
    logic              r_aw_got;
    logic              r_w_got;
    logic              r_aw_ok;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [DATA_W-1:0] r_wr_data;
    logic [STRB_W-1:0] r_wr_strb;
    logic [1:0]        r_bresp;

    logic              w_awready;
    logic              w_wready;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_ok;
    logic              w_bvalid;
    logic              w_wr_en;
    logic [FULL_W-1:0] w_aw_full;

    // AW and W are captured independently; each ready drops once its own
    // beat is held and both reopen only after the B handshake.
    assign w_awready = (r_wstate == W_IDLE) && !r_aw_got;
    assign w_wready  = (r_wstate == W_IDLE) && !r_w_got;
    assign w_aw_hs   = s_axi.AWVALID && w_awready;
    assign w_w_hs    = s_axi.WVALID && w_wready;
    assign w_aw_full = s_axi.AWADDR[ADDR_W-1:LSB];
    assign w_aw_ok   = (32'(w_aw_full) < 32'(NUM_REGS));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_wnext  = r_wstate;
        w_wr_en  = 1'b0;
        w_bvalid = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) begin
                    w_wnext = W_EXEC;
                end
            end
            W_EXEC: begin
                w_wr_en = r_aw_ok;
                w_wnext = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.BREADY) begin
                    w_wnext = W_IDLE;
                end
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_got <= 1'b1;
                r_aw_ok  <= w_aw_ok;
                r_wr_idx <= s_axi.AWADDR[LSB +: IDX_W];
            end
            if (w_w_hs) begin
                r_w_got   <= 1'b1;
                r_wr_data <= s_axi.WDATA;
                r_wr_strb <= s_axi.WSTRB;
            end
            // wr_err is only meaningful while wr_en is high in W_EXEC.
            if (r_wstate == W_EXEC) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
                r_bresp  <= (!r_aw_ok || wr_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign s_axi.AWREADY = w_awready;
    assign s_axi.WREADY  = w_wready;
    assign s_axi.BVALID  = w_bvalid;
    assign s_axi.BRESP   = r_bresp;
    assign wr_en         = w_wr_en;
    assign wr_idx        = r_wr_idx;
    assign wr_data       = r_wr_data;
    assign wr_strb       = r_wr_strb;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    axi_lite_rd_path #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_REGS   (NUM_REGS),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_rd_path (
        .clk        (ACLK),
        .rst        (ARESET),
        .i_araddr   (s_axi.ARADDR),
        .i_arvalid  (s_axi.ARVALID),
        .o_arready  (s_axi.ARREADY),
        .o_rdata    (s_axi.RDATA),
        .o_rresp    (s_axi.RRESP),
        .o_rvalid   (s_axi.RVALID),
        .i_rready   (s_axi.RREADY),
        .o_rd_en    (rd_en),
        .o_rd_idx   (rd_idx),
        .i_rd_data  (rd_data),
        .i_rd_valid (rd_valid),
        .i_rd_err   (rd_err)
    );

endmodule
`default_nettype wire
